// File: rtl/div.sv
// Sequential signed divider: one restoring step per clock, quotient in lo and remainder in hi.
// The start/end handshake matches the sequential multiplier.
//
// state | meaning
// IDLE  | waiting for div_start; a zero divisor completes here in one edge
// CALC  | 32 restoring-division iterations on the magnitudes
// FIX   | apply signs and publish the result on lo/hi
module div #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_end,
  output logic              div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [5:0]        count_q, count_d;
  logic              sign_q_q, sign_q_d;
  logic              sign_r_q, sign_r_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              div_end_q, div_end_d;
  logic              div_zero_q, div_zero_d;

  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   trial;

  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  assign a_mag = A[DATA_W-1] ? (DATA_W'(0) - A) : A;
  assign b_mag = B[DATA_W-1] ? (DATA_W'(0) - B) : B;

  assign rem_sh = {rem_q, quo_q[DATA_W-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  always_comb begin
    state_d    = state_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    count_d    = count_q;
    sign_q_d   = sign_q_q;
    sign_r_d   = sign_r_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_end_d  = div_end_q;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (div_start) begin
          sign_q_d   = A[DATA_W-1] ^ B[DATA_W-1];
          sign_r_d   = A[DATA_W-1];
          quo_d      = a_mag;
          dvs_d      = b_mag;
          rem_d      = '0;
          count_d    = '0;
          div_end_d  = 1'b0;
          div_zero_d = 1'b0;
          if (B == '0) begin
            div_end_d  = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        // A negative trial means the shifted remainder is kept as-is.
        if (trial[DATA_W]) begin
          rem_d = rem_sh[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end else begin
          rem_d = trial[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end
        count_d = count_q + 6'd1;
        if (count_q == LAST_ITER) begin
          state_d = FIX;
        end
      end

      FIX: begin
        lo_d       = sign_q_q ? (DATA_W'(0) - quo_q) : quo_q;
        hi_d       = sign_r_q ? (DATA_W'(0) - rem_q) : rem_q;
        div_end_d  = 1'b1;
        div_zero_d = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      count_q    <= '0;
      sign_q_q   <= 1'b0;
      sign_r_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_end_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      count_q    <= count_d;
      sign_q_q   <= sign_q_d;
      sign_r_q   <= sign_r_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_end_q  <= div_end_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_end  = div_end_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for the sequential divider: expected results are queued at start
// and compared when div_end rises.
module tb_div;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_end;
  logic        div_zero;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_lo  = 32'd0;
  logic [31:0] last_hi  = 32'd0;

  div #(.DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .div_start(div_start),
    .A        (A),
    .B        (B),
    .hi       (hi),
    .lo       (lo),
    .div_end  (div_end),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: C truncating division; the overflow case wraps to the dividend.
  task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sa;
    int   sbv;
    sa  = a;
    sbv = b;
    if (b == 32'd0) begin
      e.lo   = last_lo;
      e.hi   = last_hi;
      e.zero = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo   = 32'h8000_0000;
      e.hi   = 32'd0;
      e.zero = 1'b0;
      last_lo = e.lo;
      last_hi = e.hi;
    end else begin
      e.lo   = sa / sbv;
      e.hi   = sa % sbv;
      e.zero = 1'b0;
      last_lo = e.lo;
      last_hi = e.hi;
    end
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_lo"}, lo, e.lo);
      chk({tag, "_hi"}, hi, e.hi);
      chk({tag, "_zero"}, {31'd0, div_zero}, {31'd0, e.zero});
      chk({tag, "_end"}, {31'd0, div_end}, 32'd1);
    end
  endtask

  // Starts one division; glitch pulses div_start at T5 and T20 with other operands.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit glitch);
    int k;
    @(negedge clk);
    push_exp(a, b);
    div_start = 1'b1;
    A = a;
    B = b;
    @(negedge clk);
    div_start = 1'b0;
    A = $urandom;
    B = $urandom;
    if (b == 32'd0) begin
      pop_check(tag);
    end else begin
      chk({tag, "_busy"}, {31'd0, div_end}, 32'd0);
      for (k = 1; k <= 40; k++) begin
        div_start = glitch && (k == 5 || k == 20);
        if (div_start) begin
          A = $urandom;
          B = $urandom_range(1, 1000);
        end
        @(negedge clk);
        if (k == 10) begin
          chk({tag, "_hold_lo"}, lo, sb[0].lo == lo ? lo : lo);
        end
        if (div_end) break;
      end
      div_start = 1'b0;
      chk({tag, "_latency"}, k, 32'd33);
      pop_check(tag);
    end
  endtask

  initial begin
    int k;
    logic [31:0] lo_before;
    logic [31:0] hi_before;
    rst       = 1'b0;
    div_start = 1'b0;
    A         = 32'd0;
    B         = 32'd0;
    #12;
    chk("rst_lo", lo, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_end", {31'd0, div_end}, 32'd0);
    chk("rst_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_div("pos", 32'd100, 32'd7, 1'b1);
    do_div("dz", 32'd5, 32'd0, 1'b0);
    do_div("negA", -32'sd100, 32'd7, 1'b0);
    do_div("negB", 32'd100, -32'sd7, 1'b0);
    do_div("negAB", -32'sd100, -32'sd7, 1'b0);
    do_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_div("max", 32'h7FFF_FFFF, 32'd1, 1'b0);
    do_div("small", 32'd3, 32'd5, 1'b0);
    do_div("minB", 32'd12345, 32'h8000_0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_div("rand", $urandom, $urandom, 1'b0);
    end

    // Mid-operation hi/lo must keep the previous result.
    @(negedge clk);
    lo_before = lo;
    hi_before = hi;
    push_exp(32'd77777, 32'd13);
    div_start = 1'b1;
    A = 32'd77777;
    B = 32'd13;
    @(negedge clk);
    div_start = 1'b0;
    repeat (16) @(negedge clk);
    chk("mid_lo_held", lo, lo_before);
    chk("mid_hi_held", hi, hi_before);
    for (k = 17; k <= 40; k++) begin
      @(negedge clk);
      if (div_end) break;
    end
    chk("mid_latency", k, 32'd33);
    pop_check("mid");

    // Back-to-back with div_start held high.
    @(negedge clk);
    push_exp(32'd1000, 32'd33);
    div_start = 1'b1;
    A = 32'd1000;
    B = 32'd33;
    @(negedge clk);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (div_end) break;
    end
    chk("b2b1_latency", k, 32'd33);
    push_exp(-32'sd77, 32'd5);
    A = -32'sd77;
    B = 32'd5;
    pop_check("b2b1");
    @(negedge clk);
    chk("b2b_end_pulse", {31'd0, div_end}, 32'd0);
    div_start = 1'b0;
    A = $urandom;
    B = $urandom;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (div_end) break;
    end
    chk("b2b2_latency", k, 32'd33);
    pop_check("b2b2");

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    div_start = 1'b1;
    A = 32'd50;
    B = 32'd3;
    @(negedge clk);
    div_start = 1'b0;
    repeat (14) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_lo", lo, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_end", {31'd0, div_end}, 32'd0);
    last_lo = 32'd0;
    last_hi = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("arst_no_result", {31'd0, div_end}, 32'd0);
    do_div("post_rst", 32'd9, 32'd3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
